// File: rtl/fxp_seq_div.sv
// Exact signed Q(N-FRAC).FRAC divider: restoring long division, one quotient bit per cycle.
// Optional macro FXP_DIV_ROUND_EN adds a guard iteration and rounds half away from zero.
module fxp_seq_div #(
  parameter int N    = 32,
  parameter int FRAC = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] q,
  output logic         div_by_zero,
  output logic         overflow
);

`ifdef FXP_DIV_ROUND_EN
  localparam int ITER = N + FRAC + 1;
`else
  localparam int ITER = N + FRAC;
`endif
  localparam int CW = $clog2(ITER + 1);
  localparam logic [N-1:0] MAX_POS = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            r_state;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [N-1:0]      r_q;
  logic              r_dbz;
  logic              r_ovf;
  logic              r_sign;
  logic              r_b_zero;
  logic [N-1:0]      r_abs_a;
  logic [N-1:0]      r_abs_b;
  logic [N:0]        r_rem;
  logic [ITER-1:0]   r_dvd;
  logic [ITER-1:0]   r_mag;
  logic [CW-1:0]     r_cnt;

  logic [N-1:0]      w_abs_a;
  logic [N-1:0]      w_abs_b;
  logic [N+1:0]      w_rem_sh;
  logic [N+1:0]      w_diff;
  logic              w_sub_ok;
  logic [ITER-1:0]   w_mag_fin;
  logic [N:0]        w_res;

  function automatic logic [N-1:0] abs_u(input logic [N-1:0] v);
    return v[N-1] ? (~v + 1'b1) : v;
  endfunction

  // Returns {overflow, q}; a zero magnitude yields 0 whatever the sign.
  function automatic logic [N:0] saturate(input logic neg, input logic [ITER-1:0] mag);
    logic [ITER-1:0] lim_pos;
    logic [ITER-1:0] lim_neg;
    logic [N:0]      res;
    lim_pos = {{(ITER-N){1'b0}}, MAX_POS};
    lim_neg = {{(ITER-N){1'b0}}, MIN_NEG};
    if (!neg) begin
      if (mag > lim_pos) res = {1'b1, MAX_POS};
      else               res = {1'b0, mag[N-1:0]};
    end else begin
      if (mag > lim_neg) res = {1'b1, MIN_NEG};
      else               res = {1'b0, (~mag[N-1:0]) + 1'b1};
    end
    return res;
  endfunction

  function automatic logic [N-1:0] dbz_value(input logic neg, input logic a_zero);
    logic [N-1:0] res;
    if (a_zero)   res = '0;
    else if (neg) res = MIN_NEG;
    else          res = MAX_POS;
    return res;
  endfunction

`ifdef FXP_DIV_ROUND_EN
  // Drops the guard bit, adding it back in so halves round away from zero.
  function automatic logic [ITER-1:0] round_half_away(input logic [ITER-1:0] g);
    return {1'b0, g[ITER-1:1]} + {{(ITER-1){1'b0}}, g[0]};
  endfunction
`endif

  assign w_abs_a  = abs_u(a);
  assign w_abs_b  = abs_u(b);
  assign w_rem_sh = {r_rem, r_dvd[ITER-1]};
  assign w_diff   = w_rem_sh - {2'b00, r_abs_b};
  assign w_sub_ok = ~w_diff[N+1];

`ifdef FXP_DIV_ROUND_EN
  assign w_mag_fin = round_half_away(r_mag);
`else
  assign w_mag_fin = r_mag;
`endif

  assign w_res = saturate(r_sign, w_mag_fin);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_q         <= '0;
      r_dbz       <= 1'b0;
      r_ovf       <= 1'b0;
      r_sign      <= 1'b0;
      r_b_zero    <= 1'b0;
      r_abs_a     <= '0;
      r_abs_b     <= '0;
      r_rem       <= '0;
      r_dvd       <= '0;
      r_mag       <= '0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && r_in_ready) begin
            r_in_ready <= 1'b0;
            r_sign     <= a[N-1] ^ b[N-1];
            r_b_zero   <= (b == '0);
            r_abs_a    <= w_abs_a;
            r_abs_b    <= w_abs_b;
            r_rem      <= '0;
            r_mag      <= '0;
            r_dvd      <= {w_abs_a, {(ITER-N){1'b0}}};
            r_cnt      <= CW'(ITER);
            r_state    <= (b == '0) ? DONE : CALC;
          end
        end
        CALC: begin
          r_rem <= w_sub_ok ? w_diff[N:0] : w_rem_sh[N:0];
          r_mag <= {r_mag[ITER-2:0], w_sub_ok};
          r_dvd <= {r_dvd[ITER-2:0], 1'b0};
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) r_state <= DONE;
        end
        DONE: begin
          // First DONE cycle forms the result; it is then held until taken.
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            if (r_b_zero) begin
              r_q   <= dbz_value(r_sign, r_abs_a == '0);
              r_dbz <= 1'b1;
              r_ovf <= 1'b0;
            end else begin
              r_q   <= w_res[N-1:0];
              r_dbz <= 1'b0;
              r_ovf <= w_res[N];
            end
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign q           = r_q;
  assign div_by_zero = r_dbz;
  assign overflow    = r_ovf;

endmodule

// File: tb/tb_fxp_seq_div.sv
// Directed self-checking bench for fxp_seq_div (Q20.12), vector table plus handshake/reset sequences.
module tb_fxp_seq_div;

`ifdef FXP_DIV_ROUND_EN
  localparam int LAT = 46;
  localparam bit RND = 1'b1;
`else
  localparam int LAT = 45;
  localparam bit RND = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] q;
  logic        div_by_zero;
  logic        overflow;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic        dbz;
    logic        ovf;
  } vec_t;

  vec_t vecs[$];

  fxp_seq_div #(.N(32), .FRAC(12)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .q(q), .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic start_op(input logic [31:0] ta, input logic [31:0] tb_v);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("in_ready_before_op", {31'b0, in_ready}, 32'd1);
    a = ta;
    b = tb_v;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) break;
    end
  endtask

  task automatic pop();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic add(input logic [31:0] va, input logic [31:0] vb, input logic [31:0] vq,
                     input logic vdbz, input logic vovf);
    vec_t v;
    v.a = va; v.b = vb; v.q = vq; v.dbz = vdbz; v.ovf = vovf;
    vecs.push_back(v);
  endtask

  initial begin
    int lat;
    logic [31:0] hq;
    logic hd, ho, bad, busy_bad;

    add(32'h0000_3000, 32'h0000_1000, 32'h0000_3000, 1'b0, 1'b0);
    add(32'h0000_1000, 32'h0000_3000, 32'h0000_0555, 1'b0, 1'b0);
    add(32'h0000_2000, 32'h0000_3000, RND ? 32'h0000_0AAB : 32'h0000_0AAA, 1'b0, 1'b0);
    add(32'hFFFF_E000, 32'h0000_0800, 32'hFFFF_C000, 1'b0, 1'b0);
    add(32'h8000_0000, 32'h0000_1000, 32'h8000_0000, 1'b0, 1'b0);
    add(32'h0000_5000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0);
    add(32'h4000_0000, 32'h0000_0800, 32'h7FFF_FFFF, 1'b0, 1'b1);
    add(32'hFFFF_B000, 32'h0000_0000, 32'h8000_0000, 1'b1, 1'b0);
    add(32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0);
    add(32'h0000_0000, 32'hFFFF_D000, 32'h0000_0000, 1'b0, 1'b0);
    add(32'hFFFF_E000, 32'h0000_3000, RND ? 32'hFFFF_F555 : 32'hFFFF_F556, 1'b0, 1'b0);
    add(32'h8000_0000, 32'hFFFF_F800, 32'h7FFF_FFFF, 1'b0, 1'b1);
    add(32'hC000_0000, 32'h0000_0800, 32'h8000_0000, 1'b0, 1'b0);
    add(32'hC000_0000, 32'h0000_07FF, 32'h8000_0000, 1'b0, 1'b1);
    add(32'h0000_0001, 32'h7FFF_FFFF, 32'h0000_0000, 1'b0, 1'b0);
    add(32'hFFFF_FFFF, 32'h0000_2000, RND ? 32'hFFFF_FFFF : 32'h0000_0000, 1'b0, 1'b0);

    // Reset state
    #12;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_q", q, 32'd0);
    chk("rst_flags", {30'b0, div_by_zero, overflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      start_op(vecs[i].a, vecs[i].b);
      wait_done(lat);
      chk($sformatf("v%0d_latency", i), 32'(lat), vecs[i].dbz ? 32'd1 : 32'(LAT));
      chk($sformatf("v%0d_q", i), q, vecs[i].q);
      chk($sformatf("v%0d_div_by_zero", i), {31'b0, div_by_zero}, {31'b0, vecs[i].dbz});
      chk($sformatf("v%0d_overflow", i), {31'b0, overflow}, {31'b0, vecs[i].ovf});
      pop();
      chk($sformatf("v%0d_out_valid_after_pop", i), {31'b0, out_valid}, 32'd0);
    end

    // Output backpressure: result and flags frozen, no new operand accepted
    start_op(32'h0000_7000, 32'h0000_1000);
    wait_done(lat);
    chk("stall_q", q, 32'h0000_7000);
    hq = q; hd = div_by_zero; ho = overflow;
    bad = 1'b0;
    busy_bad = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (q !== hq || div_by_zero !== hd || overflow !== ho || out_valid !== 1'b1) bad = 1'b1;
      if (in_ready !== 1'b0) busy_bad = 1'b1;
    end
    chk("stall_outputs_held", {31'b0, bad}, 32'd0);
    chk("stall_in_ready_low", {31'b0, busy_bad}, 32'd0);
    pop();

    // in_valid pulsed mid-CALC must be ignored
    start_op(32'h0000_1000, 32'h0000_3000);
    repeat (5) @(negedge clk);
    a = 32'h0000_7000;
    b = 32'h0000_1000;
    in_valid = 1'b1;
    busy_bad = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (in_ready !== 1'b0) busy_bad = 1'b1;
    end
    in_valid = 1'b0;
    a = '0;
    b = '0;
    chk("busy_in_ready_low", {31'b0, busy_bad}, 32'd0);
    wait_done(lat);
    chk("busy_out_valid", {31'b0, out_valid}, 32'd1);
    chk("busy_q", q, 32'h0000_0555);
    pop();
    bad = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0) bad = 1'b1;
    end
    chk("busy_no_ghost_result", {31'b0, bad}, 32'd0);

    // Asynchronous reset in the middle of CALC aborts the operation
    start_op(32'h0000_7000, 32'h0000_1000);
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
    chk("abort_q", q, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start_op(32'h0000_6000, 32'h0000_2000);
    wait_done(lat);
    chk("after_reset_latency", 32'(lat), 32'(LAT));
    chk("after_reset_q", q, 32'h0000_3000);
    chk("after_reset_flags", {30'b0, div_by_zero, overflow}, 32'd0);
    pop();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
